// File: rtl/io_stage_if.sv
// Bundle of the execute->IO->writeback handshake, SRAM read data and decode bypass record.
// The master side (execute/writeback/SRAM/decode) drives the inputs; io_stage is the slave.
interface io_stage_if #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5
);
    localparam int EX_W  = 2 * DATA_WIDTH + REGISTER_ADDRESS_WIDTH + 3;
    localparam int WB_W  = 2 * DATA_WIDTH + REGISTER_ADDRESS_WIDTH + 2;
    localparam int FWD_W = DATA_WIDTH + REGISTER_ADDRESS_WIDTH + 1;

    logic                  wb_allow_in;
    logic                  io_allow_in;
    logic [EX_W-1:0]       ex_to_io_bus;
    logic [DATA_WIDTH-1:0] data_read_data;
    logic [WB_W-1:0]       io_to_wb_bus;
    logic [FWD_W-1:0]      io_forward_bus;

    modport master (
        output wb_allow_in,
        output ex_to_io_bus,
        output data_read_data,
        input  io_allow_in,
        input  io_to_wb_bus,
        input  io_forward_bus
    );

    modport slave (
        input  wb_allow_in,
        input  ex_to_io_bus,
        input  data_read_data,
        output io_allow_in,
        output io_to_wb_bus,
        output io_forward_bus
    );
endinterface

// File: rtl/io_stage.sv
// Memory-access stage: merges synchronous SRAM read data with the ALU result and
// keeps load data in a one-entry hold register across writeback back-pressure.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no instruction in the stage
// S_FRESH | first cycle of occupancy, SRAM output belongs to this instr
// S_HELD  | later cycles of a stall, load data comes from r_held_data
module io_stage #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5
) (
    input  logic        clock,
    input  logic        reset,
    io_stage_if.slave   bus
);
    localparam int DW   = DATA_WIDTH;
    localparam int RAW  = REGISTER_ADDRESS_WIDTH;
    localparam int EX_W = 2 * DW + RAW + 3;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FRESH = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_pc;
    logic [DW-1:0]   r_alu_result;
    logic [DW-1:0]   r_held_data;
    logic [RAW-1:0]  r_dest;
    logic            r_reg_write;
    logic            r_from_mem;

    logic            w_ex_valid;
    logic [DW-1:0]   w_ex_pc;
    logic [DW-1:0]   w_ex_alu_result;
    logic [RAW-1:0]  w_ex_dest;
    logic            w_ex_reg_write;
    logic            w_ex_from_mem;

    logic            w_io_valid;
    logic            w_allow_in;
    logic            w_accept;
    logic [DW-1:0]   w_load_value;
    logic [DW-1:0]   w_final_result;
    logic            w_write_pending;

    assign w_ex_valid      = bus.ex_to_io_bus[EX_W-1];
    assign w_ex_pc         = bus.ex_to_io_bus[RAW+2+DW +: DW];
    assign w_ex_alu_result = bus.ex_to_io_bus[RAW+2 +: DW];
    assign w_ex_dest       = bus.ex_to_io_bus[2 +: RAW];
    assign w_ex_reg_write  = bus.ex_to_io_bus[1];
    assign w_ex_from_mem   = bus.ex_to_io_bus[0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // wb_allow_in only steers the next state; the bus fields never see it.
    always_comb begin
        w_state_next = r_state;
        w_io_valid   = (r_state != S_EMPTY);
        w_allow_in   = !w_io_valid || bus.wb_allow_in;
        w_accept     = w_allow_in && w_ex_valid;
        w_load_value = r_held_data;
        if (r_state == S_FRESH) begin
            w_load_value = bus.data_read_data;
        end
        w_final_result = r_from_mem ? w_load_value : r_alu_result;
        if (w_allow_in) begin
            w_state_next = w_ex_valid ? S_FRESH : S_EMPTY;
        end else if (r_state == S_FRESH) begin
            w_state_next = S_HELD;
        end
    end

    // Captured fields survive bubbles; downstream qualifies them with valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc         <= '0;
            r_alu_result <= '0;
            r_dest       <= '0;
            r_reg_write  <= 1'b0;
            r_from_mem   <= 1'b0;
            r_held_data  <= '0;
        end else begin
            if (w_accept) begin
                r_pc         <= w_ex_pc;
                r_alu_result <= w_ex_alu_result;
                r_dest       <= w_ex_dest;
                r_reg_write  <= w_ex_reg_write;
                r_from_mem   <= w_ex_from_mem;
            end
            if (r_state == S_FRESH) begin
                r_held_data <= bus.data_read_data;
            end
        end
    end

    assign w_write_pending = w_io_valid && r_reg_write && (r_dest != '0);

    assign bus.io_allow_in    = w_allow_in;
    assign bus.io_to_wb_bus   = {w_io_valid, r_pc, w_final_result, r_dest, r_reg_write};
    assign bus.io_forward_bus = {w_write_pending, r_dest, w_final_result};
endmodule

// File: doc/io_stage.md
# io_stage

Memory-access (IO) stage of the five-stage MIPS core, directly downstream of the execute stage and upstream of writeback. It accepts one instruction per cycle from execute over a valid/allow-in handshake. It merges the synchronous data-SRAM read result with the ALU result and presents the final value to writeback. It also publishes a bypass record to decode. A one-entry hold register keeps load data intact across writeback back-pressure, because the SRAM output is valid only in the first cycle an instruction occupies this stage.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and PC width
- REGISTER_ADDRESS_WIDTH, 5, GPR index width

Ports:
- clock  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-low reset; `reset == 0` at a rising edge clears state
- wb_allow_in  in  1  writeback can accept this cycle
- io_allow_in  out  1  this stage can accept from execute
- ex_to_io_bus  in  72  {valid, program_count[31:0], alu_result[31:0], destination_register[4:0], register_write, result_is_from_memory}, MSB first
- data_read_data  in  32  data-SRAM read data; valid in the cycle after the address was presented by execute
- io_to_wb_bus  out  71  {valid, program_count[31:0], final_result[31:0], destination_register[4:0], register_write}
- io_forward_bus  out  38  {write_pending, destination_register[4:0], value[31:0]} to decode bypass/interlock

## Operation
- Registers: io_valid, captured bus fields (pc, alu_result, dest, register_write, result_is_from_memory), held_data[31:0], 2-bit state.
- State machine:
  - EMPTY: io_valid = 0.
  - FRESH: first cycle of occupancy; SRAM output belongs to this instruction.
  - HELD: later cycles; SRAM output is stale.
- Transitions at each clock edge:
  - On accept (io_allow_in && ex valid): go to FRESH.
  - FRESH with wb_allow_in = 0: go to HELD.
  - Any state with io_allow_in && !ex valid: go to EMPTY.
  - HELD with wb_allow_in = 0: stay in HELD.
- Field capture: on accept, load the bus fields. Otherwise hold them.
- held_data capture: in FRESH, load held_data <= data_read_data on every edge, whether or not the stage advances.
- load_value: equals data_read_data in FRESH and held_data in HELD.
- final_result: equals load_value when result_is_from_memory = 1, else alu_result.
- Ready/valid rules:
  - ready_go = 1.
  - io_allow_in = !io_valid || wb_allow_in.
  - io_to_wb_bus.valid = io_valid.
- Forwarding:
  - write_pending = io_valid && register_write && destination_register != 0.
  - value = final_result.
  - destination_register passes through.
- Bubbles: when io_valid = 0 the captured fields are not cleared; downstream qualifies everything with valid.
- No store handling in this stage. Stores are issued by execute and arrive here with register_write = 0.

## Timing
- Reset values: io_valid = 0, state = EMPTY, all captured fields and held_data = 0.
- Reset outputs: io_allow_in = 1, io_to_wb_bus = 0, io_forward_bus = 0.
- Reset mid-operation: the instruction being held is dropped. The next cycle shows valid = 0 and io_allow_in = 1.
- Latency: one cycle. An instruction accepted at edge N appears on io_to_wb_bus during cycle N..N+1 and leaves at the first edge where wb_allow_in = 1.
- Throughput: one instruction per cycle when wb_allow_in = 1 continuously.
- Simultaneous events: when writeback takes the current instruction and execute offers a new one in the same cycle, the new one enters FRESH. Its load_value must come from the new SRAM data, never from held_data.
- Output paths: final_result and forward value are combinational from registered state plus data_read_data in FRESH only. No combinational path from wb_allow_in to any bus field.
- Stalls: any stall length is allowed. The value in HELD is constant for the entire stall.

## Test plan
- Reset and handshake:
  - Stimulus: hold reset = 0 for 2 cycles with ex valid = 1, then release.
  - Required response: io_to_wb_bus.valid = 0 and io_allow_in = 1 during reset; the first instruction appears exactly 1 cycle after its accept.
- Load, no stall:
  - Stimulus: lw with pc = 0xBFC00010, dest = 8; data_read_data = 0xDEADBEEF in the FRESH cycle; wb_allow_in = 1.
  - Required response: final_result = 0xDEADBEEF; forward = {1, 8, 0xDEADBEEF}.
- Load under stall:
  - Stimulus: as above, but wb_allow_in = 0 for 3 cycles, and data_read_data changes to 0x12345678 after FRESH.
  - Required response: final_result stays 0xDEADBEEF for all 4 cycles; io_allow_in = 0 for 3 cycles.
- Back-to-back:
  - Stimulus: addu (alu_result 0x5, dest 3), then lw (SRAM 0xA5A5A5A5, dest 4) on consecutive cycles.
  - Required response: writeback sees 0x5 and then 0xA5A5A5A5 in consecutive cycles with no bubble.
- Register 0 and store:
  - Stimulus: an instruction with dest = 0 and register_write = 1, then a sw.
  - Required response: write_pending = 0 for both; valid = 1 for both.
- Mid-stall reset:
  - Stimulus: assert reset while in HELD.
  - Required response: next cycle valid = 0, held_data = 0, state = EMPTY.
